output_port_scheduler: RTL and testbench
========================================

// Module: output_port_scheduler
// PURPOSE
// Per-output-port scheduler for the mesh router: shares one crossbar output among the N/S/W/E/L
// input buffers with wormhole packet locking and downstream credit accounting. One instance per
// output port; drives the crossbar mux select and the input-buffer read strobes for that port.
// Round-robin fairness among packets; flits of a granted packet go back-to-back until its tail.
// PARAMETERS
// N_IN        5   number of requesting input ports (index 0=N,1=S,2=W,3=E,4=L)
// CREDIT_MAX  8   downstream buffer depth; credit counter reset value
// CNT_W       4   credit counter width; must hold CREDIT_MAX
// PORTS
// clk           in   1       clock, all state on rising edge
// reset         in   1       asynchronous, active-low reset
// req_i         in   N_IN    input i has a flit for this output (buffer non-empty, route matches)
// tail_i        in   N_IN    head-of-queue flit of input i is a packet tail (head+tail = 1-flit pkt)
// credit_inc_i  in   1       downstream freed one buffer slot (1-cycle pulse)
// read_o        out  N_IN    one-hot pop strobe to input buffer i; flit crosses crossbar this cycle
// mux_sel_o     out  3       crossbar mux select = index of read_o bit; 0 when idle
// valid_o       out  1       flit forwarded downstream this cycle (= |read_o)
// credits_o     out  CNT_W   current credit count
// locked_o      out  1       packet in progress (state LOCKED)
// err_o         out  1       sticky: credit_inc_i received with credits at CREDIT_MAX
// BEHAVIOUR
// - Reset (reset=0): state IDLE, rr_ptr=0, owner=0, credits=CREDIT_MAX, err_o=0; read_o, valid_o,
//   mux_sel_o, locked_o forced 0 combinationally while reset is low.
// - read_o/mux_sel_o/valid_o are combinational from registered state + req_i/tail_i (zero latency,
//   so the buffer pops in the same cycle it requests; no over-read when one flit remains).
// - A flit may be sent only if credits > 0. No send ever occurs with credits == 0.
// - IDLE: if credits>0 and any req_i, pick first requester at or after rr_ptr (wrapping N_IN-1->0);
//   assert its read_o. Next: rr_ptr <= winner+1 (mod N_IN). If tail_i[winner] -> stay IDLE
//   (1-flit packet), else owner <= winner, -> LOCKED.
// - LOCKED: only owner is served; other req_i ignored. If req_i[owner] && credits>0 -> read_o[owner];
//   if that flit has tail_i[owner] -> IDLE next cycle. Owner bubble (req low) or credits==0 ->
//   stall, stay LOCKED, no output.
// - Credits: send & ~inc -> -1; inc & ~send -> +1; both -> unchanged. Inc at CREDIT_MAX (no send):
//   saturate, set err_o (cleared only by reset).
// - Arbitration in IDLE is not performed while credits==0; rr_ptr unchanged on stall.
// - Reset mid-packet: returns to IDLE immediately; partial packet is the upstream's problem.
// - Max throughput one flit/cycle; a new packet can start the cycle after a tail is sent.
// STRUCTURE
// - router_pkg: N_PORTS=5, port index constants (PORT_N..PORT_L), FLIT_W=16, sched_state_e
//   {IDLE, LOCKED}; shared with crossbar and route-compute blocks.
// - Sub-module rr_pick: combinational N_IN-wide round-robin picker (req, ptr -> one-hot, index, any).
// - Top: state/owner/rr_ptr registers, credit counter, output decode.
// TESTING
// 1 Reset: hold reset=0, req_i=5'b11111 -> read_o=0, credits_o=8, locked_o=0; release -> grant idx0.
// 2 RR: req_i=5'b10110 all 1-flit, credits plenty -> grants idx1,2,4,1,2 on consecutive cycles.
// 3 Wormhole: idx3 sends 3-flit pkt (tail on 3rd), idx0 requesting -> 3,3,3 then 0; locked_o 3 cyc.
// 4 Credits: 9 single flits, no inc -> 8 sent, stall at credits_o=0; one inc -> 9th sent next cycle.
// 5 Simultaneous send+inc at credits=5 -> stays 5; inc at 8 with no send -> 8, err_o=1.
// 6 Reset mid-packet (LOCKED, owner=2) -> IDLE, credits=8, next grant follows rr_ptr=0.

Source files
------------

// File: rtl/output_port_scheduler_pkg.sv
// Shared router definitions: port indices, flit width, scheduler states and
// a small index helper used by the output-port scheduler.
package output_port_scheduler_pkg;

  localparam int N_PORTS = 5;
  localparam int PORT_N  = 0;
  localparam int PORT_S  = 1;
  localparam int PORT_W  = 2;
  localparam int PORT_E  = 3;
  localparam int PORT_L  = 4;
  localparam int FLIT_W  = 16;

  // Width of a port index / crossbar select.
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_e;

  // Advance a port index by one, wrapping at n-1 back to 0.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W-1:0] res;
    if (int'(idx) >= n - 1) begin
      res = {IDX_W{1'b0}};
    end else begin
      res = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/output_port_scheduler_if.sv
// Handshake bundle between the input buffers / downstream credit return and
// one output-port scheduler.
interface output_port_scheduler_if #(
  parameter int N_IN  = 5,
  parameter int CNT_W = 4
);
  import output_port_scheduler_pkg::*;

  logic [N_IN-1:0]  req_i;
  logic [N_IN-1:0]  tail_i;
  logic             credit_inc_i;
  logic [N_IN-1:0]  read_o;
  logic [IDX_W-1:0] mux_sel_o;
  logic             valid_o;
  logic [CNT_W-1:0] credits_o;
  logic             locked_o;
  logic             err_o;

  // Side that presents requests and credits and observes the schedule.
  modport master (
    output req_i, tail_i, credit_inc_i,
    input  read_o, mux_sel_o, valid_o, credits_o, locked_o, err_o
  );

  // The scheduler itself.
  modport slave (
    input  req_i, tail_i, credit_inc_i,
    output read_o, mux_sel_o, valid_o, credits_o, locked_o, err_o
  );

endinterface

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational round-robin picker: selects the first requester at or after
// ptr_i, wrapping from N_IN-1 back to 0.
module output_port_scheduler_rr_pick
  import output_port_scheduler_pkg::*;
#(
  parameter int N_IN = 5
) (
  input  logic [N_IN-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_IN-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan N_IN positions starting at the pointer; the first hit wins.
  always_comb begin
    grant_o = {N_IN{1'b0}};
    idx_o   = {IDX_W{1'b0}};
    any_o   = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      automatic int pos = int'(ptr_i) + k;
      if (pos >= N_IN) begin
        pos = pos - N_IN;
      end else begin
        pos = pos;
      end
      if (!any_o && (pos < N_IN) && req_i[pos]) begin
        any_o        = 1'b1;
        idx_o        = IDX_W'(pos);
        grant_o[pos] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: shares one crossbar output among the input buffers.
// Packets are granted round-robin and then held (wormhole) until their tail
// flit is sent; every flit consumes one downstream credit.
module output_port_scheduler
  import output_port_scheduler_pkg::*;
#(
  parameter int N_IN       = 5,
  parameter int CREDIT_MAX = 8,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output_port_scheduler_if.slave  bus
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic             err_q, err_d;

  logic [N_IN-1:0]  pick_grant_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;

  logic [N_IN-1:0]  read_s;
  logic [IDX_W-1:0] sel_s;
  logic             send_s;
  logic             sent_tail_s;
  logic             credit_ok_s;

  localparam logic [CNT_W-1:0] CRED_FULL = CNT_W'(CREDIT_MAX);
  localparam logic [CNT_W-1:0] CRED_ONE  = CNT_W'(1);

  output_port_scheduler_rr_pick #(.N_IN(N_IN)) u_rr_pick (
    .req_i   (bus.req_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  assign credit_ok_s = (credits_q != {CNT_W{1'b0}});

  // Decode this cycle's pop strobe and mux select; nothing moves while reset is low.
  always_comb begin
    read_s = {N_IN{1'b0}};
    sel_s  = {IDX_W{1'b0}};
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (credit_ok_s && pick_any_s) begin
            read_s = pick_grant_s;
            sel_s  = pick_idx_s;
          end else begin
            read_s = {N_IN{1'b0}};
          end
        end
        LOCKED: begin
          if (credit_ok_s && bus.req_i[owner_q]) begin
            read_s[owner_q] = 1'b1;
            sel_s           = owner_q;
          end else begin
            read_s = {N_IN{1'b0}};
          end
        end
        default: begin
          read_s = {N_IN{1'b0}};
        end
      endcase
    end else begin
      read_s = {N_IN{1'b0}};
    end
  end

  assign send_s      = |read_s;
  assign sent_tail_s = |(read_s & bus.tail_i);

  // Packet lock and round-robin pointer: a non-tail grant from IDLE locks the owner.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (send_s) begin
          rr_ptr_d = wrap_inc(pick_idx_s, N_IN);
          if (!sent_tail_s) begin
            owner_d = pick_idx_s;
            state_d = LOCKED;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (send_s && sent_tail_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Credit counter: sends consume, returns refill, a return at full saturates and flags.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (send_s && !bus.credit_inc_i) begin
      credits_d = credits_q - CRED_ONE;
    end else if (bus.credit_inc_i && !send_s) begin
      if (credits_q >= CRED_FULL) begin
        credits_d = CRED_FULL;
        err_d     = 1'b1;
      end else begin
        credits_d = credits_q + CRED_ONE;
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // State, pointer, owner, credit and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= {IDX_W{1'b0}};
      owner_q   <= {IDX_W{1'b0}};
      credits_q <= CRED_FULL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign bus.read_o    = read_s;
  assign bus.mux_sel_o = sel_s;
  assign bus.valid_o   = send_s;
  assign bus.credits_o = credits_q;
  assign bus.locked_o  = reset && (state_q == LOCKED);
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed scenarios followed by random
// traffic, all checked against a packet-level reference model.
module tb_output_port_scheduler;

  logic clk;
  logic reset;

  output_port_scheduler_if #(.N_IN(5), .CNT_W(4)) bus ();

  output_port_scheduler #(.N_IN(5), .CREDIT_MAX(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: packet lock, owner, fairness pointer, credits, error.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cred;
  bit m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant(input logic [4:0] req);
    if (m_cred == 0) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < 5; k++) begin
      int i;
      i = (m_ptr + k) % 5;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_cred   = 8;
    m_err    = 1'b0;
  endtask

  // Pull reset low (optionally with requests pending), check quiet outputs, release.
  task automatic do_reset(input logic [4:0] hold_req);
    @(negedge clk);
    bus.req_i        = hold_req;
    bus.tail_i       = 5'b11111;
    bus.credit_inc_i = 1'b0;
    reset            = 1'b0;
    model_reset();
    #1;
    check_val("rst_read",   32'(bus.read_o),    32'd0);
    check_val("rst_valid",  32'(bus.valid_o),   32'd0);
    check_val("rst_sel",    32'(bus.mux_sel_o), 32'd0);
    check_val("rst_locked", 32'(bus.locked_o),  32'd0);
    check_val("rst_cred",   32'(bus.credits_o), 32'd8);
    check_val("rst_err",    32'(bus.err_o),     32'd0);
    @(negedge clk);
    bus.req_i        = 5'b00000;
    bus.tail_i       = 5'b00000;
    reset            = 1'b1;
  endtask

  // One cycle: drive inputs, compare against the model, optionally against a
  // fixed expected grant (-1 = no send, -2 = no fixed expectation), then advance.
  task automatic step(input logic [4:0] req, input logic [4:0] tail, input logic inc,
                      input int exp_sel);
    int g;
    @(negedge clk);
    bus.req_i        = req;
    bus.tail_i       = tail;
    bus.credit_inc_i = inc;
    #1;
    g = exp_grant(req);
    check_val("read",    32'(bus.read_o),    (g >= 0) ? (32'd1 << g) : 32'd0);
    check_val("sel",     32'(bus.mux_sel_o), (g >= 0) ? 32'(g) : 32'd0);
    check_val("valid",   32'(bus.valid_o),   (g >= 0) ? 32'd1 : 32'd0);
    check_val("credits", 32'(bus.credits_o), 32'(m_cred));
    check_val("locked",  32'(bus.locked_o),  32'(m_locked));
    check_val("err",     32'(bus.err_o),     32'(m_err));
    if (exp_sel == -1) begin
      check_val("dir_idle", 32'(bus.valid_o), 32'd0);
    end else if (exp_sel >= 0) begin
      check_val("dir_valid", 32'(bus.valid_o), 32'd1);
      check_val("dir_sel",   32'(bus.mux_sel_o), 32'(exp_sel));
    end
    @(posedge clk);
    if (g >= 0) begin
      if (!m_locked) begin
        m_ptr = (g + 1) % 5;
        if (!tail[g]) begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else if (tail[g]) begin
        m_locked = 1'b0;
      end
    end
    if ((g >= 0) && !inc) begin
      m_cred = m_cred - 1;
    end else if (inc && (g < 0)) begin
      if (m_cred == 8) m_err = 1'b1;
      else m_cred = m_cred + 1;
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.req_i        = 5'b00000;
    bus.tail_i       = 5'b00000;
    bus.credit_inc_i = 1'b0;
    model_reset();

    // Reset with every input requesting, then first grant goes to index 0.
    do_reset(5'b11111);
    step(5'b11111, 5'b11111, 1'b0, 0);

    // Round robin over single-flit packets from inputs 1, 2 and 4.
    do_reset(5'b00000);
    step(5'b10110, 5'b11111, 1'b1, 1);
    step(5'b10110, 5'b11111, 1'b1, 2);
    step(5'b10110, 5'b11111, 1'b1, 4);
    step(5'b10110, 5'b11111, 1'b1, 1);
    step(5'b10110, 5'b11111, 1'b1, 2);

    // Wormhole: input 3 sends a 3-flit packet while input 0 waits.
    do_reset(5'b00000);
    step(5'b00100, 5'b00100, 1'b1, 2);
    step(5'b01001, 5'b00001, 1'b0, 3);
    #1 check_val("t3_locked", 32'(bus.locked_o), 32'd1);
    step(5'b01001, 5'b00001, 1'b0, 3);
    step(5'b01001, 5'b01001, 1'b0, 3);
    #1 check_val("t3_unlock", 32'(bus.locked_o), 32'd0);
    step(5'b01001, 5'b01001, 1'b0, 0);

    // Credit exhaustion: eight sends, stall, one return, then the ninth flit.
    do_reset(5'b00000);
    for (int i = 0; i < 8; i++) step(5'b00001, 5'b00001, 1'b0, 0);
    step(5'b00001, 5'b00001, 1'b0, -1);
    #1 check_val("t4_cred0", 32'(bus.credits_o), 32'd0);
    step(5'b00001, 5'b00001, 1'b1, -1);
    step(5'b00001, 5'b00001, 1'b0, 0);

    // Send and return together at 5 credits; return at full credits flags error.
    do_reset(5'b00000);
    for (int i = 0; i < 3; i++) step(5'b00001, 5'b00001, 1'b0, -2);
    step(5'b00001, 5'b00001, 1'b1, -2);
    #1 check_val("t5_cred5", 32'(bus.credits_o), 32'd5);
    do_reset(5'b00000);
    step(5'b00000, 5'b00000, 1'b1, -1);
    #1 check_val("t5_err", 32'(bus.err_o), 32'd1);
    check_val("t5_cred8", 32'(bus.credits_o), 32'd8);

    // Reset in the middle of a packet owned by input 2.
    do_reset(5'b00000);
    step(5'b00100, 5'b00000, 1'b0, 2);
    #1 check_val("t6_locked", 32'(bus.locked_o), 32'd1);
    do_reset(5'b00100);
    step(5'b11111, 5'b11111, 1'b0, 0);

    // Random traffic with occasional resets.
    do_reset(5'b00000);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(5'($urandom));
      end else begin
        step(5'($urandom), 5'($urandom), ($urandom_range(0, 99) < 40), -2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
